// File: rtl/seq_div_if.sv
// rtl/seq_div_if.sv - start/valid handshake and operand/result bundle for seq_div
interface seq_div_if #(
    parameter int WA = 12,
    parameter int WB = 6
);
    logic          start;
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic [WA-1:0] q;
    logic [WB-1:0] r;
    logic          busy;
    logic          valid;
    logic          dz;

    modport master (
        output start, a, b,
        input  q, r, busy, valid, dz
    );

    modport slave (
        input  start, a, b,
        output q, r, busy, valid, dz
    );
endinterface

// File: rtl/seq_div.sv
// rtl/seq_div.sv - iterative restoring divider, one quotient bit per clock MSB first; SEQ_DIV_SIGNED_EN selects two's-complement operands
module seq_div #(
    parameter int WA = 12,
    parameter int WB = 6
) (
    input  logic      clk,
    input  logic      rst,
    seq_div_if.slave  bus
);
    localparam int CW = $clog2(WA);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [WA-1:0] dvd;
    logic [WA-1:0] quo;
    logic [WB-1:0] dsr;
    logic [WB-1:0] rem;
    logic [CW-1:0] cnt;
    logic [WA-1:0] q_reg;
    logic [WB-1:0] r_reg;
    logic          dz_reg;

    logic [WB:0]   p;
    logic          ge;
    logic [WB-1:0] diff;
    logic [WB-1:0] rem_nx;
    logic [WA-1:0] quo_nx;
    logic [WA-1:0] q_fin;
    logic [WB-1:0] r_fin;
    logic [WA-1:0] a_mag;
    logic [WB-1:0] b_mag;
    logic          last;
    logic          b_zero;

    assign last   = (cnt == '0);
    assign b_zero = (bus.b == '0);

    // One restoring step: p is the (WB+1)-bit partial remainder. When p >= divisor
    // the true difference is below the divisor, so a WB-bit subtraction is exact.
    assign p      = {rem, dvd[WA-1]};
    assign ge     = (p >= {1'b0, dsr});
    assign diff   = p[WB-1:0] - dsr;
    assign rem_nx = ge ? diff : p[WB-1:0];
    assign quo_nx = {quo[WA-2:0], ge};

`ifdef SEQ_DIV_SIGNED_EN
    logic sa;
    logic sb;

    // Divide magnitudes; the most-negative value maps onto its unsigned magnitude.
    assign a_mag = bus.a[WA-1] ? (WA'(0) - bus.a) : bus.a;
    assign b_mag = bus.b[WB-1] ? (WB'(0) - bus.b) : bus.b;
    // Truncate toward zero: quotient sign from both operands, remainder follows dividend.
    assign q_fin = (sa ^ sb) ? (WA'(0) - quo_nx) : quo_nx;
    assign r_fin = sa ? (WB'(0) - rem_nx) : rem_nx;
`else
    assign a_mag = bus.a;
    assign b_mag = bus.b;
    assign q_fin = quo_nx;
    assign r_fin = rem_nx;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: start is only looked at outside RUN; zero divisor short-cuts to DONE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nx = b_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture on accept, one shift/subtract per RUN edge, result load.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd    <= '0;
            quo    <= '0;
            dsr    <= '0;
            rem    <= '0;
            cnt    <= '0;
            q_reg  <= '0;
            r_reg  <= '0;
            dz_reg <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            sa     <= 1'b0;
            sb     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (b_zero) begin
                            q_reg  <= '1;
                            r_reg  <= '0;
                            dz_reg <= 1'b1;
                        end else begin
                            dvd <= a_mag;
                            dsr <= b_mag;
                            rem <= '0;
                            quo <= '0;
                            cnt <= CW'(WA - 1);
`ifdef SEQ_DIV_SIGNED_EN
                            sa  <= bus.a[WA-1];
                            sb  <= bus.b[WB-1];
`endif
                        end
                    end
                end
                RUN: begin
                    dvd <= {dvd[WA-2:0], 1'b0};
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt - 1'b1;
                    if (last) begin
                        q_reg  <= q_fin;
                        r_reg  <= r_fin;
                        dz_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.q     = q_reg;
    assign bus.r     = r_reg;
    assign bus.dz    = dz_reg;
    assign bus.busy  = (state == RUN);
    assign bus.valid = (state == DONE);
endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - directed self-checking bench for seq_div
module tb_seq_div;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    seq_div_if #(.WA(12), .WB(6)) bus ();

    seq_div #(.WA(12), .WB(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept edge, then count edges until valid (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [11:0] ta, input logic [5:0] tbv,
                          input logic [11:0] eq, input logic [5:0] er, input logic edz,
                          input int elat);
        int n;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tbv;
        tick();
        bus.start = 1'b0;
        if (elat > 0) begin
            check({tag, ".valid_drop"}, 32'(bus.valid), 32'd0);
            check({tag, ".busy"}, 32'(bus.busy), 32'd1);
        end
        wait_valid(n);
        check({tag, ".lat"}, 32'(n), 32'(elat));
        check({tag, ".q"}, 32'(bus.q), 32'(eq));
        check({tag, ".r"}, 32'(bus.r), 32'(er));
        check({tag, ".dz"}, 32'(bus.dz), 32'(edz));
        check({tag, ".busy_done"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int  n;
        bit  seen;
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst.q", 32'(bus.q), 32'd0);
        check("rst.r", 32'(bus.r), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.valid", 32'(bus.valid), 32'd0);
        check("rst.dz", 32'(bus.dz), 32'd0);

        run_op("d143_13", 12'd143, 6'd13, 12'd11, 6'd0, 1'b0, 12);
        run_op("d100_7", 12'd100, 6'd7, 12'd14, 6'd2, 1'b0, 12);
        run_op("d4095_1", 12'd4095, 6'd1, 12'd4095, 6'd0, 1'b0, 12);
        run_op("d55_0", 12'd55, 6'd0, 12'hFFF, 6'd0, 1'b1, 0);
        run_op("d3969_63", 12'd3969, 6'd63, 12'd63, 6'd0, 1'b0, 12);
        run_op("d4095_63", 12'd4095, 6'd63, 12'd65, 6'd0, 1'b0, 12);
        run_op("d5_6", 12'd5, 6'd6, 12'd0, 6'd5, 1'b0, 12);
        run_op("d0_0_again", 12'd0, 6'd0, 12'hFFF, 6'd0, 1'b1, 0);

        // Abort with reset during RUN.
        bus.start = 1'b1;
        bus.a     = 12'd200;
        bus.b     = 6'd9;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        check("abort.busy_pre", 32'(bus.busy), 32'd1);
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        check("abort.q", 32'(bus.q), 32'd0);
        check("abort.r", 32'(bus.r), 32'd0);
        check("abort.valid", 32'(bus.valid), 32'd0);
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.dz", 32'(bus.dz), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.valid || bus.busy) seen = 1'b1;
        end
        check("abort.no_pulse", 32'(seen), 32'd0);
        run_op("d200_9", 12'd200, 6'd9, 12'd22, 6'd2, 1'b0, 12);

        // start and operands wiggled during RUN must be ignored.
        bus.start = 1'b1;
        bus.a     = 12'd1000;
        bus.b     = 6'd11;
        tick();
        n = 0;
        while (!bus.valid && n < 40) begin
            bus.start = ~bus.start;
            bus.a     = bus.a + 12'd37;
            bus.b     = bus.b + 6'd5;
            tick();
            n++;
        end
        bus.start = 1'b0;
        check("ign.lat", 32'(n), 32'd12);
        check("ign.q", 32'(bus.q), 32'd90);
        check("ign.r", 32'(bus.r), 32'd10);
        tick();
        check("ign.hold_q", 32'(bus.q), 32'd90);
        check("ign.hold_valid", 32'(bus.valid), 32'd1);

`ifdef SEQ_DIV_SIGNED_EN
        run_op("s_m100_7", 12'hF9C, 6'd7, 12'hFF2, 6'h3E, 1'b0, 12);
        run_op("s_100_m7", 12'd100, 6'h39, 12'hFF2, 6'd2, 1'b0, 12);
        run_op("s_m2048_m1", 12'h800, 6'h3F, 12'h800, 6'd0, 1'b0, 12);
        run_op("s_m7_m2", 12'hFF9, 6'h3E, 12'd3, 6'h3F, 1'b0, 12);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
